// File: rtl/full_adder_4bit_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_4bit_pkg;

    localparam int unsigned ADDER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/full_adder_4bit_1bit.sv
// One-bit full-adder cell, purely combinational; chained to form the ripple carry.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder_4bit.sv
// Registered ripple-carry adder: {Co,S} = A + B + Ci, captured each rising clk edge.
module full_adder_4bit
    import full_adder_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             co_d;
    logic             co_q;

    assign carry[0] = Ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1bit u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (s_d[i]),
            .co (carry[i+1])
        );
    end

    assign co_d = carry[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign S  = s_q;
    assign Co = co_q;

endmodule

// File: tb/tb_full_adder_4bit.sv
// Directed bench for full_adder_4bit: reset, exhaustive sweeps, ripple, latency, mid-stream reset.
module tb_full_adder_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] S;
    logic       Co;
    logic [3:0] A;
    logic [3:0] B;
    logic       Ci;

    int unsigned checks;
    int unsigned failures;

    full_adder_4bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .S   (S),
        .Co  (Co),
        .A   (A),
        .B   (B),
        .Ci  (Ci)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {Co, S};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed={Co,S}=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp_sum;
        checks   = 0;
        failures = 0;

        // Reset with nonzero inputs and running clock
        rst = 1'b1; A = 4'h5; B = 4'h3; Ci = 1'b1;
        #1;
        chk("reset_immediate", 5'h00);
        @(posedge clk); #1;
        chk("reset_hold_edge1", 5'h00);
        @(posedge clk); #1;
        chk("reset_hold_edge2", 5'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_release_no_edge", 5'h00);
        @(posedge clk); #1;
        chk("first_capture_5_3_1", 5'h09);

        // Hand-computed directed vectors
        @(negedge clk); A = 4'h7; B = 4'h8; Ci = 1'b0;
        @(posedge clk); #1; chk("dir_7_8_0", 5'h0F);
        @(negedge clk); A = 4'h8; B = 4'h8; Ci = 1'b0;
        @(posedge clk); #1; chk("dir_8_8_0", 5'h10);
        @(negedge clk); A = 4'h0; B = 4'h0; Ci = 1'b1;
        @(posedge clk); #1; chk("dir_0_0_1", 5'h01);
        @(negedge clk); A = 4'hF; B = 4'hF; Ci = 1'b1;
        @(posedge clk); #1; chk("wrap_F_F_1", 5'h1F);
        @(negedge clk); A = 4'hF; B = 4'h0; Ci = 1'b1;
        @(posedge clk); #1; chk("ripple_F_0_1", 5'h10);

        // Input changes between edges must not reach the outputs
        @(negedge clk); A = 4'hA; B = 4'h3; Ci = 1'b0;
        #2;
        chk("stable_between_edges", 5'h10);
        @(posedge clk); #1; chk("stable_capture_A_3_0", 5'h0D);

        // Latency/throughput: one result per clock, one cycle behind
        @(negedge clk); A = 4'h1; B = 4'h1; Ci = 1'b0;
        @(posedge clk); #1; chk("tput_1_1_0", 5'h02);
        @(negedge clk); A = 4'h2; B = 4'h2; Ci = 1'b0;
        @(posedge clk); #1; chk("tput_2_2_0", 5'h04);
        @(negedge clk); A = 4'hF; B = 4'h1; Ci = 1'b0;
        @(posedge clk); #1; chk("tput_F_1_0", 5'h10);

        // Exhaustive sweeps for both carry-in values
        for (int unsigned c = 0; c < 2; c++) begin
            for (int unsigned a = 0; a < 16; a++) begin
                for (int unsigned b = 0; b < 16; b++) begin
                    @(negedge clk);
                    A = a[3:0]; B = b[3:0]; Ci = c[0];
                    exp_sum = 5'(a) + 5'(b) + 5'(c);
                    @(posedge clk); #1;
                    chk($sformatf("sweep_a%0d_b%0d_c%0d", a, b, c), exp_sum);
                end
            end
        end

        // Mid-stream reset: in-flight operands discarded, outputs clear at once
        @(negedge clk); A = 4'h6; B = 4'h7; Ci = 1'b1;
        @(posedge clk); #1; chk("pre_reset_6_7_1", 5'h0E);
        @(negedge clk); A = 4'h9; B = 4'h9; Ci = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_immediate", 5'h00);
        @(posedge clk); #1; chk("midreset_hold", 5'h00);
        @(negedge clk); rst = 1'b0; A = 4'h3; B = 4'h4; Ci = 1'b0;
        #1;
        chk("midreset_release_no_edge", 5'h00);
        @(posedge clk); #1; chk("midreset_first_3_4_0", 5'h07);
        @(negedge clk); A = 4'hC; B = 4'h5; Ci = 1'b1;
        @(posedge clk); #1; chk("midreset_next_C_5_1", 5'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
